// File: rtl/exception_ctrl_if.sv
// Exception controller bus: decoder/IRQ inputs, redirect/kill/ack/read-mux outputs.
// Latency: none (wires only).
// Backpressure: none; level IRQ is held by the source until ExtIAck pulses.
interface exception_ctrl_if #(
  parameter int N = 64
);
  logic [3:0]   EStatus;
  logic         ERet;
  logic         ExtIRQ;
  logic [N-1:0] PC;
  logic         SysSel;
  logic         Exc;
  logic [N-1:0] ExcPC;
  logic         Kill;
  logic         ExtIAck;
  logic [N-1:0] SysData;
  logic         Halt;

  // Core/decoder side: drives status and PC, consumes redirect controls.
  modport master (
    output EStatus, ERet, ExtIRQ, PC, SysSel,
    input  Exc, ExcPC, Kill, ExtIAck, SysData, Halt
  );

  // Controller side.
  modport slave (
    input  EStatus, ERet, ExtIRQ, PC, SysSel,
    output Exc, ExcPC, Kill, ExtIAck, SysData, Halt
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: takes sync exceptions, illegal ERET and level IRQ, holds ELR/ESR.
// Latency: redirect/kill/ack combinational in the event cycle; ELR/ESR/state update next edge.
// Backpressure: IRQ is level; masked in HANDLER and for one instruction after ERET (holdoff).
module exception_ctrl #(
  parameter int           N      = 64,
  parameter logic [N-1:0] VECTOR = N'(64'hD8)
) (
  input  logic              clk,
  input  logic              reset,
  exception_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam logic [3:0] ESR_IRQ       = 4'b0001;
  localparam logic [3:0] ESR_ILL_ERET  = 4'b0011;

  state_t       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         holdoff_q, holdoff_d;

  logic         exc, kill, ack, halt;
  logic [N-1:0] exc_pc;

  // State, ELR, ESR and holdoff registers; reset beats any event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      elr_q     <= '0;
      esr_q     <= '0;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elr_q     <= elr_d;
      esr_q     <= esr_d;
      holdoff_q <= holdoff_d;
    end
  end

  // Event priority, next-state and combinational redirect/kill/ack decisions.
  always_comb begin
    state_d   = state_q;
    elr_d     = elr_q;
    esr_d     = esr_q;
    holdoff_d = holdoff_q;
    exc       = 1'b0;
    kill      = 1'b0;
    ack       = 1'b0;
    halt      = 1'b0;
    exc_pc    = VECTOR;

    case (state_q)
      ST_RUN: begin
        // Any RUN cycle consumes the post-ERET holdoff.
        holdoff_d = 1'b0;
        if (bus.EStatus != 4'b0000) begin
          exc     = 1'b1;
          kill    = 1'b1;
          elr_d   = bus.PC;
          esr_d   = bus.EStatus;
          state_d = ST_HANDLER;
        end else if (bus.ERet) begin
          // ERET outside a handler is itself an exception.
          exc     = 1'b1;
          kill    = 1'b1;
          elr_d   = bus.PC;
          esr_d   = ESR_ILL_ERET;
          state_d = ST_HANDLER;
        end else if (bus.ExtIRQ && !holdoff_q) begin
          // Instruction at PC is squashed and re-executed on return.
          exc     = 1'b1;
          kill    = 1'b1;
          ack     = 1'b1;
          elr_d   = bus.PC;
          esr_d   = ESR_IRQ;
          state_d = ST_HANDLER;
        end
      end

      ST_HANDLER: begin
        if (bus.EStatus != 4'b0000) begin
          // Fault inside the handler: keep ELR of the original fault for post-mortem.
          kill    = 1'b1;
          esr_d   = bus.EStatus;
          state_d = ST_HALT;
        end else if (bus.ERet) begin
          exc       = 1'b1;
          exc_pc    = elr_q;
          holdoff_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_HALT: begin
        kill = 1'b1;
        halt = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are quiet while reset is asserted, whatever the current state.
    if (reset) begin
      exc    = 1'b0;
      kill   = 1'b0;
      ack    = 1'b0;
      halt   = 1'b0;
      exc_pc = VECTOR;
    end
  end

  assign bus.Exc     = exc;
  assign bus.ExcPC   = exc_pc;
  assign bus.Kill    = kill;
  assign bus.ExtIAck = ack;
  assign bus.Halt    = halt;
  assign bus.SysData = bus.SysSel ? {{(N-4){1'b0}}, esr_q} : elr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: reset, sync exception, ERET/holdoff, collisions, double fault.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
// Every check compares against hand-computed constants.
module tb_exception_ctrl;

  localparam int           N      = 64;
  localparam logic [N-1:0] VECTOR = 64'hD8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exception_ctrl_if #(.N(N)) bus ();

  exception_ctrl #(.N(N), .VECTOR(VECTOR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] est, input logic eret, input logic irq,
                       input logic [N-1:0] pc, input logic sel);
    bus.EStatus = est;
    bus.ERet    = eret;
    bus.ExtIRQ  = irq;
    bus.PC      = pc;
    bus.SysSel  = sel;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b0010, 1'b0, 1'b1, 64'h40, 1'b0);
    tick();
    drive(4'b0010, 1'b0, 1'b1, 64'h40, 1'b0);
    checks++; if (bus.Exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %0b want 0", bus.Exc); end
    checks++; if (bus.Kill !== 1'b0) begin errors++; $display("FAIL reset_kill: got %0b want 0", bus.Kill); end
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", bus.ExtIAck); end
    checks++; if (bus.Halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0b want 0", bus.Halt); end
    checks++; if (bus.ExcPC !== VECTOR) begin errors++; $display("FAIL reset_excpc: got %h want %h", bus.ExcPC, VECTOR); end
    checks++; if (bus.SysData !== 64'h0) begin errors++; $display("FAIL reset_elr: got %h want 0", bus.SysData); end
    drive(4'b0010, 1'b0, 1'b1, 64'h40, 1'b1);
    checks++; if (bus.SysData !== 64'h0) begin errors++; $display("FAIL reset_esr: got %h want 0", bus.SysData); end
    // First cycle after release: stuck IRQ accepted immediately.
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 64'h100, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b1) begin errors++; $display("FAIL release_ack: got %0b want 1", bus.ExtIAck); end
    checks++; if (bus.Exc !== 1'b1 || bus.Kill !== 1'b1) begin errors++; $display("FAIL release_exc_kill: got %0b%0b want 11", bus.Exc, bus.Kill); end
    checks++; if (bus.ExcPC !== VECTOR) begin errors++; $display("FAIL release_excpc: got %h want %h", bus.ExcPC, VECTOR); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b0);
    checks++; if (bus.SysData !== 64'h100) begin errors++; $display("FAIL irq_elr: got %h want 100", bus.SysData); end
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b1);
    checks++; if (bus.SysData !== 64'h1) begin errors++; $display("FAIL irq_esr: got %h want 1", bus.SysData); end
    // Return and burn the holdoff cycle.
    drive(4'b0000, 1'b1, 1'b0, 64'hDC, 1'b0);
    checks++; if (bus.Exc !== 1'b1 || bus.ExcPC !== 64'h100) begin errors++; $display("FAIL irq_ret: exc=%0b pc=%h want 1/100", bus.Exc, bus.ExcPC); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h100, 1'b0);
    tick();
  endtask

  task automatic test_sync_exc();
    drive(4'b0010, 1'b0, 1'b0, 64'h40, 1'b0);
    checks++; if (bus.Exc !== 1'b1) begin errors++; $display("FAIL sync_exc: got %0b want 1", bus.Exc); end
    checks++; if (bus.Kill !== 1'b1) begin errors++; $display("FAIL sync_kill: got %0b want 1", bus.Kill); end
    checks++; if (bus.ExcPC !== 64'hD8) begin errors++; $display("FAIL sync_excpc: got %h want d8", bus.ExcPC); end
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL sync_ack: got %0b want 0", bus.ExtIAck); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b0);
    checks++; if (bus.SysData !== 64'h40) begin errors++; $display("FAIL sync_elr: got %h want 40", bus.SysData); end
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b1);
    checks++; if (bus.SysData !== 64'h2) begin errors++; $display("FAIL sync_esr: got %h want 2", bus.SysData); end
    checks++; if (bus.Exc !== 1'b0 || bus.Kill !== 1'b0) begin errors++; $display("FAIL handler_idle: got %0b%0b want 00", bus.Exc, bus.Kill); end
  endtask

  task automatic test_eret_holdoff();
    // Handler with ELR=0x40; IRQ stuck high during and after the return.
    drive(4'b0000, 1'b1, 1'b1, 64'hE0, 1'b0);
    checks++; if (bus.Exc !== 1'b1) begin errors++; $display("FAIL eret_exc: got %0b want 1", bus.Exc); end
    checks++; if (bus.ExcPC !== 64'h40) begin errors++; $display("FAIL eret_excpc: got %h want 40", bus.ExcPC); end
    checks++; if (bus.Kill !== 1'b0) begin errors++; $display("FAIL eret_kill: got %0b want 0", bus.Kill); end
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL eret_ack_masked: got %0b want 0", bus.ExtIAck); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h40, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b0 || bus.Exc !== 1'b0 || bus.Kill !== 1'b0) begin errors++; $display("FAIL holdoff: ack/exc/kill=%0b%0b%0b want 000", bus.ExtIAck, bus.Exc, bus.Kill); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h44, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b1 || bus.Exc !== 1'b1 || bus.Kill !== 1'b1) begin errors++; $display("FAIL post_holdoff_ack: ack/exc/kill=%0b%0b%0b want 111", bus.ExtIAck, bus.Exc, bus.Kill); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'hD8, 1'b0);
    checks++; if (bus.SysData !== 64'h44) begin errors++; $display("FAIL post_holdoff_elr: got %h want 44", bus.SysData); end
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL handler_irq_masked: got %0b want 0", bus.ExtIAck); end
    drive(4'b0000, 1'b1, 1'b0, 64'hDC, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h44, 1'b0);
    tick();
  endtask

  task automatic test_simultaneous();
    drive(4'b0010, 1'b0, 1'b1, 64'h80, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL simul_ack: got %0b want 0", bus.ExtIAck); end
    checks++; if (bus.Exc !== 1'b1 || bus.Kill !== 1'b1) begin errors++; $display("FAIL simul_exc_kill: got %0b%0b want 11", bus.Exc, bus.Kill); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'hD8, 1'b0);
    checks++; if (bus.SysData !== 64'h80) begin errors++; $display("FAIL simul_elr: got %h want 80", bus.SysData); end
    drive(4'b0000, 1'b0, 1'b1, 64'hD8, 1'b1);
    checks++; if (bus.SysData !== 64'h2) begin errors++; $display("FAIL simul_esr: got %h want 2", bus.SysData); end
    // Pending IRQ survives the handler and is taken after return plus holdoff.
    drive(4'b0000, 1'b1, 1'b1, 64'hDC, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h80, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL simul_holdoff: got %0b want 0", bus.ExtIAck); end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 64'h84, 1'b0);
    checks++; if (bus.ExtIAck !== 1'b1) begin errors++; $display("FAIL simul_pending_ack: got %0b want 1", bus.ExtIAck); end
    tick();
    drive(4'b0000, 1'b1, 1'b0, 64'hD8, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'h84, 1'b0);
    tick();
  endtask

  task automatic test_illegal_eret();
    drive(4'b0000, 1'b1, 1'b0, 64'h10, 1'b0);
    checks++; if (bus.Exc !== 1'b1 || bus.Kill !== 1'b1) begin errors++; $display("FAIL ill_eret_exc_kill: got %0b%0b want 11", bus.Exc, bus.Kill); end
    checks++; if (bus.ExcPC !== 64'hD8) begin errors++; $display("FAIL ill_eret_excpc: got %h want d8", bus.ExcPC); end
    tick();
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b0);
    checks++; if (bus.SysData !== 64'h10) begin errors++; $display("FAIL ill_eret_elr: got %h want 10", bus.SysData); end
    drive(4'b0000, 1'b0, 1'b0, 64'hD8, 1'b1);
    checks++; if (bus.SysData !== 64'h3) begin errors++; $display("FAIL ill_eret_esr: got %h want 3", bus.SysData); end
  endtask

  task automatic test_double_fault();
    // Still in the handler entered by the illegal ERET (ELR=0x10).
    drive(4'b0010, 1'b0, 1'b0, 64'hDC, 1'b0);
    checks++; if (bus.Kill !== 1'b1 || bus.Exc !== 1'b0) begin errors++; $display("FAIL dfault_kill_exc: got %0b%0b want 10", bus.Kill, bus.Exc); end
    checks++; if (bus.Halt !== 1'b0) begin errors++; $display("FAIL dfault_halt_early: got %0b want 0", bus.Halt); end
    tick();
    drive(4'b0000, 1'b1, 1'b1, 64'hE0, 1'b0);
    checks++; if (bus.Halt !== 1'b1 || bus.Kill !== 1'b1) begin errors++; $display("FAIL halt_state: halt/kill=%0b%0b want 11", bus.Halt, bus.Kill); end
    checks++; if (bus.Exc !== 1'b0 || bus.ExtIAck !== 1'b0) begin errors++; $display("FAIL halt_ignores: exc/ack=%0b%0b want 00", bus.Exc, bus.ExtIAck); end
    checks++; if (bus.SysData !== 64'h10) begin errors++; $display("FAIL halt_elr: got %h want 10", bus.SysData); end
    drive(4'b0000, 1'b1, 1'b1, 64'hE0, 1'b1);
    checks++; if (bus.SysData !== 64'h2) begin errors++; $display("FAIL halt_esr: got %h want 2", bus.SysData); end
    tick();
    drive(4'b0100, 1'b1, 1'b1, 64'hE4, 1'b0);
    checks++; if (bus.Halt !== 1'b1 || bus.SysData !== 64'h10) begin errors++; $display("FAIL halt_frozen: halt=%0b elr=%h want 1/10", bus.Halt, bus.SysData); end
    tick();
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 64'h0, 1'b0);
    checks++; if (bus.Halt !== 1'b0 || bus.Kill !== 1'b0) begin errors++; $display("FAIL halt_reset_out: halt/kill=%0b%0b want 00", bus.Halt, bus.Kill); end
    tick();
    reset = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 64'h0, 1'b0);
    checks++; if (bus.Halt !== 1'b0 || bus.Kill !== 1'b0 || bus.SysData !== 64'h0) begin errors++; $display("FAIL halt_reset_run: halt/kill=%0b%0b elr=%h want 00/0", bus.Halt, bus.Kill, bus.SysData); end
    // Back in RUN: a sync exception is taken normally again.
    drive(4'b0101, 1'b0, 1'b0, 64'h8, 1'b0);
    checks++; if (bus.Exc !== 1'b1 || bus.ExcPC !== 64'hD8) begin errors++; $display("FAIL after_reset_exc: exc=%0b pc=%h want 1/d8", bus.Exc, bus.ExcPC); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.EStatus = 4'b0000;
    bus.ERet    = 1'b0;
    bus.ExtIRQ  = 1'b0;
    bus.PC      = '0;
    bus.SysSel  = 1'b0;
    test_reset();
    test_sync_exc();
    test_eret_holdoff();
    test_simultaneous();
    test_illegal_eret();
    test_double_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
